// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack, redirect input and
// the valid/ready instruction hand-off to decode.
interface instruction_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4,
    input  imem_ack, imem_rdata, redirect_valid, redirect_target, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4,
    output imem_ack, imem_rdata, redirect_valid, redirect_target, instr_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// MIPS instruction fetch: owns the PC, issues one request at a time to a
// variable-latency imem and hands each word to decode via a one-entry register.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] PC_INC       = 32'd4
) (
  input logic                         clk,
  input logic                         reset,
  instruction_fetch_unit_if.master    fi
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt, tgt;
  logic        cap;

  assign tgt = {fi.redirect_target[31:2], 2'b00};

  // Redirect outranks ack/ready; a response that coincides with a redirect
  // belongs to the abandoned path and is dropped.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cap       = 1'b0;
    unique case (state)
      IDLE: begin
        state_nxt = REQ;
        if (fi.redirect_valid) pc_nxt = tgt;
      end
      REQ: begin
        if (fi.redirect_valid) begin
          pc_nxt    = tgt;
          state_nxt = fi.imem_ack ? REQ : DRAIN;
        end else if (fi.imem_ack) begin
          cap       = 1'b1;
          pc_nxt    = pc + PC_INC;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (fi.redirect_valid) begin
          pc_nxt    = tgt;
          state_nxt = REQ;
        end else if (fi.instr_ready) begin
          state_nxt = REQ;
        end
      end
      DRAIN: begin
        if (fi.redirect_valid) pc_nxt = tgt;
        if (fi.imem_ack)       state_nxt = REQ;
      end
    endcase
  end

  // imem_addr doubles as the latched in-flight address: it only follows pc
  // when the next state is REQ, so DRAIN keeps presenting the abandoned one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= IDLE;
      pc                <= RESET_VECTOR;
      fi.imem_req       <= 1'b0;
      fi.imem_addr      <= RESET_VECTOR;
      fi.instr_valid    <= 1'b0;
      fi.instr          <= '0;
      fi.instr_pc       <= '0;
      fi.instr_pc_plus4 <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      fi.imem_req <= (state_nxt == REQ) || (state_nxt == DRAIN);
      if (state_nxt == REQ) fi.imem_addr <= pc_nxt;
      if (cap) begin
        fi.instr          <= fi.imem_rdata;
        fi.instr_pc       <= pc;
        fi.instr_pc_plus4 <= pc + PC_INC;
        fi.instr_valid    <= 1'b1;
      end else if (state_nxt != HOLD) begin
        fi.instr_valid    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed + random bench for instruction_fetch_unit against a
// transaction-level model of which PC must be delivered next.
module tb_instruction_fetch_unit;
  localparam logic [31:0] RV = 32'hBFC00000;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   lat   = 0;
  int   wait_cnt = 0;
  int   ndeliv = 0;
  logic [31:0] exp_pc = RV;

  // pre-edge snapshot used by the model
  logic        s_rst, s_red, s_req, s_ack, s_valid, s_ready;
  logic [31:0] s_tgt, s_addr, s_instr, s_pc;

  instruction_fetch_unit_if fi();

  instruction_fetch_unit dut (.clk(clk), .reset(reset), .fi(fi));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'hBFC00000) return 32'h20080005;
    if (a == 32'hBFC00004) return 32'h20090007;
    return {a[15:0], a[31:16]} ^ 32'h13579BDF;
  endfunction

  // memory: acks after 'lat' wait cycles, data is a pure function of address
  assign fi.imem_ack   = fi.imem_req && (wait_cnt >= lat);
  assign fi.imem_rdata = mem(fi.imem_addr);
  always @(posedge clk) wait_cnt <= (fi.imem_req && !fi.imem_ack) ? wait_cnt + 1 : 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // After a redirect the next delivered word is at the target; after a
  // delivery the next one is 4 bytes on. Plus handshake/hold invariants.
  task automatic model();
    if (!s_rst) begin
      exp_pc = RV;
      chk("rst_valid", fi.instr_valid, 0);
      chk("rst_req", fi.imem_req, 0);
      chk("rst_addr", fi.imem_addr, RV);
      chk("rst_instr", fi.instr, 0);
      chk("rst_pc", fi.instr_pc, 0);
      chk("rst_pc4", fi.instr_pc_plus4, 0);
    end else begin
      if (s_red) begin
        exp_pc = {s_tgt[31:2], 2'b00};
        chk("redir_drop", fi.instr_valid, 0);
      end
      if (s_req && !s_ack) begin
        chk("req_stable", fi.imem_req, 1);
        chk("addr_stable", fi.imem_addr, s_addr);
      end
      if (s_valid && !s_ready && !s_red) begin
        chk("hold_valid", fi.instr_valid, 1);
        chk("hold_instr", fi.instr, s_instr);
        chk("hold_pc", fi.instr_pc, s_pc);
      end
      if (s_valid && (s_ready || s_red)) chk("xfer_clear", fi.instr_valid, 0);
      if (fi.instr_valid) chk("no_req_in_hold", fi.imem_req, 0);
      if (fi.imem_req) chk("addr_align", fi.imem_addr[1:0], 0);
      if (fi.instr_valid && !s_valid) begin
        chk("rise_after_ack", s_req && s_ack, 1);
        chk("deliv_pc", fi.instr_pc, exp_pc);
        chk("deliv_instr", fi.instr, mem(exp_pc));
        chk("deliv_pc4", fi.instr_pc_plus4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        ndeliv++;
      end
    end
  endtask

  task automatic cyc();
    #1;
    s_rst = reset; s_red = fi.redirect_valid; s_tgt = fi.redirect_target;
    s_req = fi.imem_req; s_ack = fi.imem_ack; s_addr = fi.imem_addr;
    s_valid = fi.instr_valid; s_ready = fi.instr_ready;
    s_instr = fi.instr; s_pc = fi.instr_pc;
    @(posedge clk);
    @(negedge clk);
    model();
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!fi.instr_valid && n < max) begin
      cyc();
      n++;
    end
    chk("wait_valid", fi.instr_valid, 1);
  endtask

  initial begin
    reset = 1'b0;
    fi.redirect_valid = 1'b0;
    fi.redirect_target = '0;
    fi.instr_ready = 1'b1;
    repeat (3) cyc();

    // zero-wait streaming, one instruction per two cycles
    reset = 1'b1;
    cyc(); chk("s1_req", fi.imem_req, 1); chk("s1_addr", fi.imem_addr, RV);
    chk("s1_v0", fi.instr_valid, 0);
    cyc(); chk("s1_v1", fi.instr_valid, 1); chk("s1_i0", fi.instr, 32'h20080005);
    chk("s1_pc0", fi.instr_pc, RV); chk("s1_p40", fi.instr_pc_plus4, 32'hBFC00004);
    cyc(); chk("s1_v2", fi.instr_valid, 0); chk("s1_addr1", fi.imem_addr, 32'hBFC00004);
    cyc(); chk("s1_v3", fi.instr_valid, 1); chk("s1_i1", fi.instr, 32'h20090007);
    chk("s1_pc1", fi.instr_pc, 32'hBFC00004); chk("s1_p41", fi.instr_pc_plus4, 32'hBFC00008);

    // ack three cycles late: request held for four cycles
    lat = 3;
    for (int i = 0; i < 4; i++) begin
      cyc(); chk("s2_req", fi.imem_req, 1); chk("s2_addr", fi.imem_addr, 32'hBFC00008);
      chk("s2_v", fi.instr_valid, 0);
    end
    cyc(); chk("s2_vrise", fi.instr_valid, 1); chk("s2_pc", fi.instr_pc, 32'hBFC00008);

    // decode stalls in HOLD
    lat = 0; fi.instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(); chk("s3_v", fi.instr_valid, 1); chk("s3_pc", fi.instr_pc, 32'hBFC00008);
      chk("s3_req", fi.imem_req, 0);
    end
    fi.instr_ready = 1'b1;
    cyc(); chk("s3_next", fi.imem_addr, 32'hBFC0000C); chk("s3_nreq", fi.imem_req, 1);
    cyc(); chk("s3_pc2", fi.instr_pc, 32'hBFC0000C);

    // redirect in HOLD
    fi.instr_ready = 1'b0; fi.redirect_valid = 1'b1; fi.redirect_target = 32'hBFC00040;
    cyc(); fi.redirect_valid = 1'b0;
    chk("s4_vdrop", fi.instr_valid, 0); chk("s4_addr", fi.imem_addr, 32'hBFC00040);
    cyc(); chk("s4_pc", fi.instr_pc, 32'hBFC00040);
    fi.instr_ready = 1'b1;

    // redirect while a request to ...08 is pending (DRAIN)
    lat = 2; fi.redirect_valid = 1'b1; fi.redirect_target = 32'hBFC00008;
    cyc(); chk("s5_addr", fi.imem_addr, 32'hBFC00008);
    fi.redirect_target = 32'hBFC00081;
    cyc(); fi.redirect_valid = 1'b0;
    chk("s5_hold1", fi.imem_addr, 32'hBFC00008); chk("s5_req1", fi.imem_req, 1);
    cyc(); chk("s5_hold2", fi.imem_addr, 32'hBFC00008);
    cyc(); chk("s5_new", fi.imem_addr, 32'hBFC00080); chk("s5_nov", fi.instr_valid, 0);
    wait_valid(8); chk("s5_pc", fi.instr_pc, 32'hBFC00080);

    // reset in DRAIN with ack in the same cycle
    fi.redirect_valid = 1'b1; fi.redirect_target = 32'hBFC00100;
    cyc(); fi.redirect_target = 32'hBFC00200;
    cyc(); fi.redirect_valid = 1'b0;
    cyc(); chk("s6_drain", fi.imem_addr, 32'hBFC00100); chk("s6_ack", fi.imem_ack, 1);
    reset = 1'b0;
    cyc(); reset = 1'b1; lat = 0;
    cyc(); chk("s6_req", fi.imem_req, 1); chk("s6_addr", fi.imem_addr, RV);

    // pc wrap
    fi.redirect_valid = 1'b1; fi.redirect_target = 32'hFFFFFFFF;
    cyc(); fi.redirect_valid = 1'b0; chk("s7_addr", fi.imem_addr, 32'hFFFFFFFC);
    cyc(); chk("s7_pc", fi.instr_pc, 32'hFFFFFFFC); chk("s7_pc4", fi.instr_pc_plus4, 0);
    cyc(); chk("s7_wrap", fi.imem_addr, 0); chk("s7_req", fi.imem_req, 1);

    // random traffic
    ndeliv = 0;
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 99) != 0);
      fi.redirect_valid = ($urandom_range(0, 7) == 0);
      fi.redirect_target = $urandom;
      fi.instr_ready = ($urandom_range(0, 3) != 0);
      lat = $urandom_range(0, 3);
      cyc();
    end
    reset = 1'b1; fi.redirect_valid = 1'b0; fi.instr_ready = 1'b1; lat = 0;
    repeat (4) cyc();
    chk("rand_progress", ndeliv > 20, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
